// File: rtl/bbuf_pkg.sv
// Shared constants and parameter-derivation helpers for the ping-pong bias buffer.
package bbuf_pkg;

    localparam int BANK_W       = 1;
    localparam int READ_LATENCY = 2;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    function automatic int calc_group_size(input int mem_w, input int data_w);
        return mem_w / data_w;
    endfunction

    function automatic int calc_group_id_w(input int group_size);
        return (group_size == 1) ? 0 : $clog2(group_size);
    endfunction

    function automatic int calc_buf_id_w(input int array_m, input int group_id_w);
        return $clog2(array_m) - group_id_w;
    endfunction

endpackage

// File: rtl/bbuf_pp_if.sv
// Memory-side write and array-side read handshakes of the bias buffer.
interface bbuf_pp_if
    import bbuf_pkg::*;
#(
    parameter int ARRAY_M        = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 256,
    parameter int BUF_ADDR_WIDTH = 9
);
    localparam int GROUP_SIZE     = calc_group_size(MEM_DATA_WIDTH, DATA_WIDTH);
    localparam int GROUP_ID_W     = calc_group_id_w(GROUP_SIZE);
    localparam int BUF_ID_W       = calc_buf_id_w(ARRAY_M, GROUP_ID_W);
    localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W;
    localparam int BUF_DATA_WIDTH = ARRAY_M * DATA_WIDTH;

    logic                      mem_write_req;
    logic [MEM_ADDR_WIDTH-1:0] mem_write_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_write_data;
    logic                      mem_write_ready;
    logic                      fill_done;
    logic                      buf_read_req;
    logic [BUF_ADDR_WIDTH-1:0] buf_read_addr;
    logic                      buf_read_ready;
    logic [BUF_DATA_WIDTH-1:0] buf_read_data;
    logic                      buf_read_valid;
    logic                      drain_done;

    modport master (
        output mem_write_req, mem_write_addr, mem_write_data, fill_done,
        output buf_read_req, buf_read_addr, drain_done,
        input  mem_write_ready, buf_read_ready, buf_read_data, buf_read_valid
    );

    modport slave (
        input  mem_write_req, mem_write_addr, mem_write_data, fill_done,
        input  buf_read_req, buf_read_addr, drain_done,
        output mem_write_ready, buf_read_ready, buf_read_data, buf_read_valid
    );

endinterface

// File: rtl/bbuf_pp_ctrl.sv
// Bank ownership FSM, flow control, protocol-error detection and read valid pipeline.
module bbuf_pp_ctrl
    import bbuf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_write_req,
    input  logic       fill_done,
    input  logic       buf_read_req,
    input  logic       drain_done,
    output logic       mem_write_ready,
    output logic       buf_read_ready,
    output logic       wr_accept,
    output logic       rd_accept,
    output logic       rd_stage_en,
    output logic       buf_read_valid,
    output logic       wr_bank,
    output logic       rd_bank,
    output logic [1:0] bank_full,
    output logic       proto_err
);
    bank_state_e             bank_st_r     [0:1];
    bank_state_e             bank_st_nxt_s [0:1];
    logic                    wr_bank_r, wr_bank_nxt_s;
    logic                    rd_bank_r, rd_bank_nxt_s;
    logic                    err_r, err_nxt_s;
    logic                    fill_ok_s, drain_ok_s;
    logic [READ_LATENCY-1:0] vld_pipe_r;

    assign bank_full       = {bank_st_r[1] == BANK_FULL, bank_st_r[0] == BANK_FULL};
    assign mem_write_ready = !bank_full[wr_bank_r];
    assign buf_read_ready  = bank_full[rd_bank_r];
    assign wr_accept       = mem_write_req && mem_write_ready;
    assign rd_accept       = buf_read_req && buf_read_ready;
    assign fill_ok_s       = fill_done && !bank_full[wr_bank_r];
    assign drain_ok_s      = drain_done && bank_full[rd_bank_r];
    assign err_nxt_s       = err_r
                           | (mem_write_req && !mem_write_ready)
                           | (buf_read_req && !buf_read_ready)
                           | (fill_done && !fill_ok_s)
                           | (drain_done && !drain_ok_s);

    // Legal fill and drain in one cycle always target different banks.
    always_comb begin
        bank_st_nxt_s = bank_st_r;
        wr_bank_nxt_s = wr_bank_r;
        rd_bank_nxt_s = rd_bank_r;
        if (fill_ok_s) begin
            bank_st_nxt_s[wr_bank_r] = BANK_FULL;
            wr_bank_nxt_s            = ~wr_bank_r;
        end else begin
            wr_bank_nxt_s = wr_bank_r;
        end
        if (drain_ok_s) begin
            bank_st_nxt_s[rd_bank_r] = BANK_EMPTY;
            rd_bank_nxt_s            = ~rd_bank_r;
        end else begin
            rd_bank_nxt_s = rd_bank_r;
        end
    end

    // State, error flag and read valid pipeline registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bank_st_r[0] <= BANK_EMPTY;
            bank_st_r[1] <= BANK_EMPTY;
            wr_bank_r    <= 1'b0;
            rd_bank_r    <= 1'b0;
            err_r        <= 1'b0;
            vld_pipe_r   <= {READ_LATENCY{1'b0}};
        end else begin
            bank_st_r[0] <= bank_st_nxt_s[0];
            bank_st_r[1] <= bank_st_nxt_s[1];
            wr_bank_r    <= wr_bank_nxt_s;
            rd_bank_r    <= rd_bank_nxt_s;
            err_r        <= err_nxt_s;
            vld_pipe_r   <= {vld_pipe_r[READ_LATENCY-2:0], rd_accept};
        end
    end

    assign rd_stage_en    = vld_pipe_r[READ_LATENCY-2];
    assign buf_read_valid = vld_pipe_r[READ_LATENCY-1];
    assign wr_bank        = wr_bank_r;
    assign rd_bank        = rd_bank_r;
    assign proto_err      = err_r;

endmodule

// File: rtl/bbuf_pp_ram.sv
// Simple dual-port block RAM with synchronous read and optional output register.
module bbuf_pp_ram #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int OUTPUT_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              oe,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] ram_r [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rd_r;

    // Write port; contents are deliberately never cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            ram_r[waddr] <= wdata;
        end
    end

    // Synchronous read stage.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_r <= ram_r[raddr];
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] out_r;

        // Output register loads only when a read reaches it, otherwise holds.
        always_ff @(posedge clk) begin
            if (!reset) begin
                out_r <= {DATA_W{1'b0}};
            end else if (oe) begin
                out_r <= rd_r;
            end
        end
        assign rdata = out_r;
    end else begin : g_noreg
        assign rdata = rd_r;
    end

endmodule

// File: rtl/bbuf_pp.sv
// Ping-pong bias buffer: one RAM per output lane, banked by the top address bit.
module bbuf_pp
    import bbuf_pkg::*;
#(
    parameter int ARRAY_M        = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 256,
    parameter int BUF_ADDR_WIDTH = 9
) (
    input  logic       clk,
    input  logic       reset,
    bbuf_pp_if.slave   bus,
    output logic       wr_bank,
    output logic       rd_bank,
    output logic [1:0] bank_full,
    output logic       proto_err
);
    localparam int GROUP_SIZE     = calc_group_size(MEM_DATA_WIDTH, DATA_WIDTH);
    localparam int GROUP_ID_W     = calc_group_id_w(GROUP_SIZE);
    localparam int BUF_ID_W       = calc_buf_id_w(ARRAY_M, GROUP_ID_W);
    localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W;
    localparam int BUF_DATA_WIDTH = ARRAY_M * DATA_WIDTH;
    localparam int RAM_ADDR_W     = BANK_W + BUF_ADDR_WIDTH;

    logic                      wr_accept_s, rd_accept_s, rd_stage_en_s;
    logic [RAM_ADDR_W-1:0]     waddr_s, raddr_s;
    logic [BUF_DATA_WIDTH-1:0] rd_data_s;

    bbuf_pp_ctrl u_ctrl (
        .clk             (clk),
        .reset           (reset),
        .mem_write_req   (bus.mem_write_req),
        .fill_done       (bus.fill_done),
        .buf_read_req    (bus.buf_read_req),
        .drain_done      (bus.drain_done),
        .mem_write_ready (bus.mem_write_ready),
        .buf_read_ready  (bus.buf_read_ready),
        .wr_accept       (wr_accept_s),
        .rd_accept       (rd_accept_s),
        .rd_stage_en     (rd_stage_en_s),
        .buf_read_valid  (bus.buf_read_valid),
        .wr_bank         (wr_bank),
        .rd_bank         (rd_bank),
        .bank_full       (bank_full),
        .proto_err       (proto_err)
    );

    // The bank bit is taken at accept time, so later bank swaps cannot redirect the access.
    assign waddr_s = {wr_bank, bus.mem_write_addr[MEM_ADDR_WIDTH-1:BUF_ID_W]};
    assign raddr_s = {rd_bank, bus.buf_read_addr};
    assign bus.buf_read_data = rd_data_s;

    for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
        logic lane_we_s;

        if (BUF_ID_W == 0) begin : g_all
            assign lane_we_s = wr_accept_s;
        end else begin : g_sel
            assign lane_we_s = wr_accept_s &&
                (bus.mem_write_addr[BUF_ID_W-1:0] == BUF_ID_W'(m / GROUP_SIZE));
        end

        bbuf_pp_ram #(
            .ADDR_W     (RAM_ADDR_W),
            .DATA_W     (DATA_WIDTH),
            .OUTPUT_REG (1)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (lane_we_s),
            .waddr (waddr_s),
            .wdata (bus.mem_write_data[(m % GROUP_SIZE)*DATA_WIDTH +: DATA_WIDTH]),
            .re    (rd_accept_s),
            .raddr (raddr_s),
            .oe    (rd_stage_en_s),
            .rdata (rd_data_s[m*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_bbuf_pp.sv
// Directed test of the ping-pong bias buffer with default parameters.
module tb_bbuf_pp;
    import bbuf_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_bank, rd_bank, proto_err;
    logic [1:0] bank_full;
    int         checks = 0;
    int         errors = 0;

    bbuf_pp_if bif ();

    bbuf_pp dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif.slave),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank),
        .bank_full (bank_full),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_word(input logic [31:0] base, input logic inc);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i*32 +: 32] = inc ? base + 32'(i) : base;
        end
        return w;
    endfunction

    function automatic logic [31:0] lane(input int m);
        return bif.buf_read_data[m*32 +: 32];
    endfunction

    task automatic do_write(input logic [10:0] addr, input logic [255:0] data);
        bif.mem_write_req  = 1'b1;
        bif.mem_write_addr = addr;
        bif.mem_write_data = data;
        tick();
        bif.mem_write_req  = 1'b0;
    endtask

    task automatic pulse_fill();
        bif.fill_done = 1'b1;
        tick();
        bif.fill_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bif.mem_write_req  = 1'b0;
        bif.mem_write_addr = 11'h000;
        bif.mem_write_data = 256'h0;
        bif.fill_done      = 1'b0;
        bif.buf_read_req   = 1'b0;
        bif.buf_read_addr  = 9'h000;
        bif.drain_done     = 1'b0;
        tick();
        do_reset();
        tick();

        // Reset / idle state
        chk("rst_bank_full", bank_full, 2'b00);
        chk("rst_wr_bank", wr_bank, 1'b0);
        chk("rst_rd_bank", rd_bank, 1'b0);
        chk("rst_valid", bif.buf_read_valid, 1'b0);
        chk("rst_data", |bif.buf_read_data, 1'b0);
        chk("rst_err", proto_err, 1'b0);
        chk("rst_wready", bif.mem_write_ready, 1'b1);
        chk("rst_rready", bif.buf_read_ready, 1'b0);

        // Fill bank 0 entry 1 for lanes 0..15, then hand it over
        do_write(11'h004, mk_word(32'h0, 1'b1));
        do_write(11'h005, mk_word(32'h8, 1'b1));
        pulse_fill();
        chk("fill_bank_full", bank_full, 2'b01);
        chk("fill_wr_bank", wr_bank, 1'b1);
        chk("fill_rready", bif.buf_read_ready, 1'b1);
        chk("fill_wready", bif.mem_write_ready, 1'b1);

        bif.buf_read_req  = 1'b1;
        bif.buf_read_addr = 9'd1;
        tick();
        bif.buf_read_req  = 1'b0;
        chk("rd_lat_t1_valid", bif.buf_read_valid, 1'b0);
        tick();
        chk("rd_lat_t2_valid", bif.buf_read_valid, 1'b1);
        for (int m = 0; m < 16; m++) begin
            chk($sformatf("rd_lane%0d", m), lane(m), 32'(m));
        end
        tick();
        chk("rd_hold_valid", bif.buf_read_valid, 1'b0);
        chk("rd_hold_data", lane(5), 32'h5);

        // Fill bank 1 while reading bank 0
        bif.buf_read_req  = 1'b1;
        bif.buf_read_addr = 9'd1;
        for (int b = 0; b < 4; b++) begin
            do_write(11'(b), mk_word(32'hA5A5A5A5, 1'b0));
        end
        chk("ovl_valid", bif.buf_read_valid, 1'b1);
        chk("ovl_data", lane(9), 32'h9);
        bif.buf_read_req = 1'b0;
        pulse_fill();
        chk("ovl_bank_full", bank_full, 2'b11);
        chk("ovl_wready", bif.mem_write_ready, 1'b0);
        chk("ovl_wr_bank", wr_bank, 1'b0);

        // Drain with a same-cycle read: that read still sees bank 0
        bif.drain_done    = 1'b1;
        bif.buf_read_req  = 1'b1;
        bif.buf_read_addr = 9'd1;
        tick();
        bif.drain_done    = 1'b0;
        bif.buf_read_req  = 1'b0;
        chk("drn_rd_bank", rd_bank, 1'b1);
        chk("drn_bank_full", bank_full, 2'b10);
        tick();
        chk("drn_valid", bif.buf_read_valid, 1'b1);
        chk("drn_lane3", lane(3), 32'h3);
        chk("drn_lane15", lane(15), 32'hF);

        bif.buf_read_req  = 1'b1;
        bif.buf_read_addr = 9'd0;
        tick();
        bif.buf_read_req  = 1'b0;
        tick();
        chk("b1_valid", bif.buf_read_valid, 1'b1);
        chk("b1_lane0", lane(0), 32'hA5A5A5A5);
        chk("b1_lane7", lane(7), 32'hA5A5A5A5);
        chk("b1_lane31", lane(31), 32'hA5A5A5A5);

        // Both banks full: writer stalls, illegal write is dropped
        do_write(11'h000, mk_word(32'h11110000, 1'b1));
        pulse_fill();
        chk("full_bank_full", bank_full, 2'b11);
        chk("full_wready", bif.mem_write_ready, 1'b0);
        chk("full_err_before", proto_err, 1'b0);
        do_write(11'h000, mk_word(32'hDEAD0000, 1'b1));
        chk("full_err_after", proto_err, 1'b1);
        bif.buf_read_req  = 1'b1;
        bif.buf_read_addr = 9'd0;
        tick();
        bif.buf_read_req  = 1'b0;
        tick();
        chk("full_rb_valid", bif.buf_read_valid, 1'b1);
        chk("full_rb_lane0", lane(0), 32'hA5A5A5A5);
        chk("full_rb_lane2", lane(2), 32'hA5A5A5A5);
        chk("full_rb_bank_full", bank_full, 2'b11);

        // Protocol errors from an empty state
        do_reset();
        tick();
        chk("pe_err_clear", proto_err, 1'b0);
        bif.drain_done = 1'b1;
        tick();
        bif.drain_done = 1'b0;
        chk("pe_drain_err", proto_err, 1'b1);
        chk("pe_drain_rd_bank", rd_bank, 1'b0);
        chk("pe_drain_full", bank_full, 2'b00);
        bif.buf_read_req  = 1'b1;
        bif.buf_read_addr = 9'd0;
        tick();
        bif.buf_read_req  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("pe_rd_novalid%0d", c), bif.buf_read_valid, 1'b0);
            tick();
        end

        // Reset in the middle of a read
        do_reset();
        tick();
        pulse_fill();
        chk("mr_rready", bif.buf_read_ready, 1'b1);
        bif.buf_read_req  = 1'b1;
        bif.buf_read_addr = 9'd0;
        tick();
        bif.buf_read_req  = 1'b0;
        reset = 1'b0;
        tick();
        chk("mr_valid_t2", bif.buf_read_valid, 1'b0);
        chk("mr_bank_full", bank_full, 2'b00);
        reset = 1'b1;
        tick();
        chk("mr_valid_t3", bif.buf_read_valid, 1'b0);
        chk("mr_data_clr", lane(0), 32'h0);

        // RAM contents survive reset
        pulse_fill();
        bif.buf_read_req  = 1'b1;
        bif.buf_read_addr = 9'd0;
        tick();
        bif.buf_read_req  = 1'b0;
        tick();
        chk("ret_valid", bif.buf_read_valid, 1'b1);
        chk("ret_lane2", lane(2), 32'h11110002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bbuf_pp.md
Name: bbuf_pp

Overview:
Double-buffered (ping-pong) bias buffer for the systolic array's ARRAY_M output lanes. The DMA/memory side fills one bank while the array side reads bias vectors from the other. Explicit fill_done/drain_done handshakes swap the banks, so bias load for tile N+1 overlaps compute of tile N. Replaces the single-bank bias buffer. Adds bank ownership, ready/valid flow control and protocol-error reporting.

Parameters:
ARRAY_M, 32, number of output lanes (power of 2)
DATA_WIDTH, 32, bias word width per lane
MEM_DATA_WIDTH, 256, memory-side write word width (multiple of DATA_WIDTH)
BUF_ADDR_WIDTH, 9, per-bank entries per lane = 2^BUF_ADDR_WIDTH
GROUP_SIZE, MEM_DATA_WIDTH/DATA_WIDTH, lanes written per memory word (derived)
GROUP_ID_W, GROUP_SIZE==1 ? 0 : clog2(GROUP_SIZE), derived
BUF_ID_W, clog2(ARRAY_M)-GROUP_ID_W, lane-group select bits (derived, may be 0)
MEM_ADDR_WIDTH, BUF_ADDR_WIDTH+BUF_ID_W, derived
BUF_DATA_WIDTH, ARRAY_M*DATA_WIDTH, derived

Ports:
clk  in  1  clock; single clock domain
reset  in  1  synchronous, active-low reset (asserted when 0)
mem_write_req  in  1  write strobe, memory side
mem_write_addr  in  MEM_ADDR_WIDTH  {local_addr, buf_id}; buf_id in the LSBs
mem_write_data  in  MEM_DATA_WIDTH  GROUP_SIZE lane words; lane m%GROUP_SIZE at slice [(m%GROUP_SIZE)*DATA_WIDTH +: DATA_WIDTH]
mem_write_ready  out  1  write bank is not full
fill_done  in  1  pulse: current write bank is complete
buf_read_req  in  1  read strobe, array side
buf_read_addr  in  BUF_ADDR_WIDTH  entry index within the read bank
buf_read_ready  out  1  read bank is full (readable)
buf_read_data  out  BUF_DATA_WIDTH  lane m at slice [m*DATA_WIDTH +: DATA_WIDTH]
buf_read_valid  out  1  buf_read_data is valid this cycle
drain_done  in  1  pulse: array has finished with the read bank
wr_bank  out  1  bank currently owned by the writer
rd_bank  out  1  bank currently owned by the reader
bank_full  out  2  full flag per bank
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset==0 at a clk edge): bank_full=0, wr_bank=0, rd_bank=0, buf_read_valid=0, buf_read_data=0, proto_err=0. RAM contents are not cleared.
- Reset asserted mid-operation discards in-flight reads: valid pipeline is cleared and no valid is produced afterwards.
- Storage: per lane, one RAM of depth 2*2^BUF_ADDR_WIDTH x DATA_WIDTH, addressed as {bank, local_addr}. The RAM has a registered output.
- Write accept: mem_write_req && mem_write_ready.
  - The accepted word is written into bank wr_bank of every lane m with m/GROUP_SIZE == buf_id, at local_addr.
  - If BUF_ID_W==0, all lanes are written and the whole address is local_addr.
- mem_write_ready = !bank_full[wr_bank], combinational from state.
- Read accept: buf_read_req && buf_read_ready.
  - The read uses bank rd_bank as sampled in the accept cycle.
  - Fixed latency of 2: accepted in cycle t -> buf_read_valid=1 and data in cycle t+2.
  - Reads are fully pipelined, one accepted per cycle.
  - buf_read_data holds its last value when valid is 0.
- buf_read_ready = bank_full[rd_bank].
- Bank FSM, per bank: EMPTY -> FULL on fill_done while wr_bank points at the bank; FULL -> EMPTY on drain_done while rd_bank points at it.
  - fill_done (legal only when !bank_full[wr_bank]): set bank_full[wr_bank], toggle wr_bank.
  - drain_done (legal only when bank_full[rd_bank]): clear bank_full[rd_bank], toggle rd_bank.
  - Legal fill_done and drain_done in the same cycle act on different banks, so both take effect.
  - Reads accepted in the drain_done cycle, and reads already in flight, complete from the old bank because the bank bit is captured at accept.
  - A write accepted in the fill_done cycle lands in the old bank before it is marked full.
- Protocol errors: any of the following sets proto_err (sticky until reset) and the offending event is ignored; no state change, no RAM write, no valid.
  - mem_write_req while !mem_write_ready
  - buf_read_req while !buf_read_ready
  - fill_done while bank full
  - drain_done while bank not full
- Both banks full: writer stalls. Both banks empty: reader stalls. No data path from writer to reader without fill_done.

Decomposition:
- Shared package (bbuf_pkg): bank-index width (1), READ_LATENCY=2 constant, and parameter-derivation helpers (GROUP_SIZE/GROUP_ID_W/BUF_ID_W).
- Sub-module bbuf_pp_ctrl: bank FSM, ready generation, error detection and the 2-stage valid/bank pipeline.
- Top level: generate loop over lanes instantiating the existing ram (block type, OUTPUT_REG=1).

Test Plan:
- Reset, then idle -> all outputs 0, mem_write_ready=1, buf_read_ready=0.
- Defaults: write addr 11'h004 (local 1, buf_id 0) with data lanes 0x0..0x7, then write addr 11'h005 (buf_id 1) with 0x8..0xF, then fill_done; read addr 1 at t -> at t+2, valid=1 and lanes 0-15 = 0x0..0xF; bank_full=2'b01, wr_bank=1.
- Overlap: during reads of bank 0, fill bank 1 with 0xA5A5A5A5 at addr 0, then fill_done; drain_done with a read in the same cycle -> that read returns bank-0 data; the next read of addr 0 returns 0xA5A5A5A5 on all lanes; rd_bank=1.
- Both full: fill two banks -> mem_write_ready=0; a write attempt gives proto_err=1 and bank data is unchanged on readback.
- Protocol errors: drain_done with bank_full=0 -> proto_err=1, rd_bank stays 0; buf_read_req when not ready -> no valid.
- Reset mid-read: read accepted at t, reset=0 at t+1 -> buf_read_valid stays 0 and bank_full=0.
